// File: rtl/pmc_pkg.sv
// Shared types and helpers for the power/mode controller.
package pmc_pkg;

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_ARM      = 2'd1,
    S_ON       = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  // Bits needed to hold the value max_val (never less than one).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser followed by a tick-sampled per-bit debouncer.
module btn_sync_debounce
  import pmc_pkg::*;
#(
  parameter int DEB_TICKS = 20,
  parameter int W         = 1
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level
);

  localparam int CW = cnt_w(DEB_TICKS);

  logic [W-1:0]  sync_p0;
  logic [W-1:0]  sync_p1;
  logic [CW-1:0] stab_cnt [W];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A bit flips only after DEB_TICKS consecutive disagreeing tick samples.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < W; i++) stab_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < W; i++) begin
        if (sync_p1[i] == level[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == CW'(DEB_TICKS - 1)) begin
          level[i]    <= sync_p1[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/power_mode_ctrl.sv
// Debounced power-button sequencer with hold-to-start arming and mode latching.
module power_mode_ctrl
  import pmc_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int DEB_TICKS  = 20,
  parameter int HOLD_TICKS = 1000,
  parameter int MODE_W     = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              power_on,
  input  logic              power_off,
  input  logic [MODE_W-1:0] mode_sel,
  output logic              engine_on,
  output logic              arming,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW  = cnt_w(DIV - 1);
  localparam int HW  = cnt_w(HOLD_TICKS);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic              pon_lvl;
  logic              poff_lvl;
  logic [MODE_W-1:0] mode_lvl;
  state_t            state;
  state_t            state_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [HW-1:0]     hold_nxt;
  logic [MODE_W-1:0] mode_nxt;
  logic              chg_nxt;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v >= HW'(HOLD_TICKS)) ? HW'(HOLD_TICKS) : v + 1'b1;
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TW'(DIV - 1));

  btn_sync_debounce #(.DEB_TICKS(DEB_TICKS), .W(1)) u_deb_pon (
    .sys_clk(sys_clk), .rst_n(rst_n), .tick(tick), .raw(power_on), .level(pon_lvl)
  );

  btn_sync_debounce #(.DEB_TICKS(DEB_TICKS), .W(1)) u_deb_poff (
    .sys_clk(sys_clk), .rst_n(rst_n), .tick(tick), .raw(power_off), .level(poff_lvl)
  );

  btn_sync_debounce #(.DEB_TICKS(DEB_TICKS), .W(MODE_W)) u_deb_mode (
    .sys_clk(sys_clk), .rst_n(rst_n), .tick(tick), .raw(mode_sel), .level(mode_lvl)
  );

  // power_off wins over everything; arming must then see a full release first.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    mode_nxt  = '0;
    chg_nxt   = 1'b0;
    if (poff_lvl) begin
      state_nxt = S_WAIT_REL;
    end else begin
      unique case (state)
        S_OFF: if (pon_lvl) state_nxt = S_ARM;
        S_ARM: begin
          if (!pon_lvl)                            state_nxt = S_OFF;
          else if (hold_cnt == HW'(HOLD_TICKS))    state_nxt = S_ON;
          else if (tick)                           hold_nxt  = sat_inc(hold_cnt);
        end
        S_ON:       state_nxt = S_ON;
        S_WAIT_REL: if (!pon_lvl) state_nxt = S_OFF;
        default:    state_nxt = S_OFF;
      endcase
    end
    if (state_nxt != S_ARM) hold_nxt = '0;
    if (state_nxt == S_ON) begin
      mode_nxt = mode_lvl;
      chg_nxt  = (state == S_ON) && (mode_lvl != mode);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_OFF;
      hold_cnt  <= '0;
      engine_on <= 1'b0;
      arming    <= 1'b0;
      mode      <= '0;
      mode_chg  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      engine_on <= (state_nxt == S_ON);
      arming    <= (state_nxt == S_ARM);
      mode      <= mode_nxt;
      mode_chg  <= chg_nxt;
    end
  end

endmodule
